interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller_pkg.sv | 48 ++++
 rtl/interrupt_controller_irq_pending_arbiter.sv | 46 ++++
 rtl/interrupt_controller.sv | 140 ++++++++++++++
 tb/tb_interrupt_controller.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared interrupt definitions: FSM states, source IDs and ISR vectors (also used by IF).
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package interrupt_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_SAVE_EPC = 3'd2,
    ST_SAVE_IDR = 3'd3,
    ST_BRANCH   = 3'd4,
    ST_ISR      = 3'd5
  } irq_state_e;

  // Source IDs double as bit positions in the pending vector.
  typedef enum logic [1:0] {
    SRC_KBD  = 2'd0,
    SRC_TICK = 2'd1,
    SRC_OVF  = 2'd2
  } irq_src_e;

  localparam int NUM_SRC = 3;

  localparam logic [15:0] KBD_ISR_VEC  = 16'h03FE;
  localparam logic [15:0] TICK_ISR_VEC = 16'h03FD;
  localparam logic [15:0] OVF_ISR_VEC  = 16'h03FF;

  // One-hot mask for a source ID; unknown IDs map to no bits.
  function automatic logic [NUM_SRC-1:0] src_onehot(logic [1:0] src);
    case (src)
      SRC_KBD:  return 3'b001;
      SRC_TICK: return 3'b010;
      SRC_OVF:  return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

  // Redirect target the IF stage loads when a branch_to_*_ISR fires.
  function automatic logic [15:0] isr_vector(logic [1:0] src);
    case (src)
      SRC_KBD:  return KBD_ISR_VEC;
      SRC_TICK: return TICK_ISR_VEC;
      SRC_OVF:  return OVF_ISR_VEC;
      default:  return KBD_ISR_VEC;
    endcase
  endfunction

endpackage

// File: rtl/interrupt_controller_irq_pending_arbiter.sv
// Per-source pending bits with fixed-priority select (overflow > tick > keyboard).
// Latency: a pulse is visible on any_pending/sel_src the cycle after it arrives.
// Backpressure: none; a set in the same cycle as a clear of that source wins.
// Ports: clk/rst; set_pulse[2:0] indexed by source ID; clr_vld/clr_src clear one
//        source; any_pending and sel_src report the highest-priority pending source.
module irq_pending_arbiter
  import interrupt_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] set_pulse,
  input  logic       clr_vld,
  input  logic [1:0] clr_src,
  output logic       any_pending,
  output logic [1:0] sel_src
);

  logic [NUM_SRC-1:0] pending_q, pending_d, clr_mask;

  always_comb begin
    clr_mask  = clr_vld ? src_onehot(clr_src) : 3'b000;
    pending_d = (pending_q & ~clr_mask) | set_pulse;
  end

  // Reset wins over a same-cycle pulse, so that pulse is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_comb begin
    any_pending = |pending_q;
    sel_src     = SRC_KBD;
    if (pending_q[SRC_OVF]) begin
      sel_src = SRC_OVF;
    end else if (pending_q[SRC_TICK]) begin
      sel_src = SRC_TICK;
    end else begin
      sel_src = SRC_KBD;
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: drains the pipe, injects EPC/IDR loads, then redirects to the ISR.
// Latency: pulse -> pending (1 cycle) -> DRAIN on the next edge when int_en; all outputs registered-state decodes.
// Backpressure: none; pulses always latch as pending, only one handler runs at a time (no nesting).
// Ports: clk, rst; keyboard_irq/keyboard_data, game_tick, stack_overflow event pulses;
//        int_en, PC_curr, reti from the core; *_hazard NOP requests, branch_to_*_ISR redirects,
//        ld_epc/ld_idr inject requests, EPC, idr_data, in_isr.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        keyboard_irq,
  input  logic [7:0]  keyboard_data,
  input  logic        game_tick,
  input  logic        stack_overflow,
  input  logic        int_en,
  input  logic [15:0] PC_curr,
  input  logic        reti,
  output logic        keyboard_hazard,
  output logic        game_tick_hazard,
  output logic        stack_overflow_hazard,
  output logic        branch_to_keyboard_ISR,
  output logic        branch_to_gametick_ISR,
  output logic        branch_to_stackoverflow_ISR,
  output logic        ld_epc,
  output logic        ld_idr,
  output logic [15:0] EPC,
  output logic [7:0]  idr_data,
  output logic        in_isr
);

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  irq_state_e  state_q, state_d;
  logic [1:0]  src_q, src_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] epc_q, epc_d;
  logic [7:0]  idr_q, idr_d;

  logic        clr_vld;
  logic        any_pending;
  logic [1:0]  sel_src;

  irq_pending_arbiter u_arb (
    .clk         (clk),
    .rst         (rst),
    .set_pulse   ({stack_overflow, game_tick, keyboard_irq}),
    .clr_vld     (clr_vld),
    .clr_src     (src_q),
    .any_pending (any_pending),
    .sel_src     (sel_src)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    epc_d   = epc_q;
    // Latest key code always wins, even mid-service.
    idr_d   = keyboard_irq ? keyboard_data : idr_q;
    clr_vld = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (int_en && any_pending) begin
          state_d = ST_DRAIN;
          src_d   = sel_src;
          epc_d   = PC_curr;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = ST_SAVE_EPC;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SAVE_EPC: begin
        state_d = (src_q == SRC_KBD) ? ST_SAVE_IDR : ST_BRANCH;
      end
      ST_SAVE_IDR: begin
        state_d = ST_BRANCH;
      end
      ST_BRANCH: begin
        clr_vld = 1'b1;
        state_d = ST_ISR;
      end
      ST_ISR: begin
        if (reti) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= SRC_KBD;
      cnt_q   <= '0;
      epc_q   <= 16'h0000;
      idr_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
      idr_q   <= idr_d;
    end
  end

  // Outputs decode only registered state, so there is no input-to-output path.
  logic hazard_phase;

  always_comb begin
    hazard_phase = (state_q == ST_DRAIN) || (state_q == ST_SAVE_EPC) ||
                   (state_q == ST_SAVE_IDR);

    keyboard_hazard       = hazard_phase && (src_q == SRC_KBD);
    game_tick_hazard      = hazard_phase && (src_q == SRC_TICK);
    stack_overflow_hazard = hazard_phase && (src_q == SRC_OVF);

    branch_to_keyboard_ISR      = (state_q == ST_BRANCH) && (src_q == SRC_KBD);
    branch_to_gametick_ISR      = (state_q == ST_BRANCH) && (src_q == SRC_TICK);
    branch_to_stackoverflow_ISR = (state_q == ST_BRANCH) && (src_q == SRC_OVF);

    ld_epc   = (state_q == ST_SAVE_EPC);
    ld_idr   = (state_q == ST_SAVE_IDR);
    in_isr   = (state_q != ST_IDLE);
    EPC      = epc_q;
    idr_data = idr_q;
  end

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

  localparam int DRAIN = 2;
  // Source indices used by the reference model.
  localparam int KBD  = 0;
  localparam int TICK = 1;
  localparam int OVF  = 2;

  logic        clk;
  logic        rst;
  logic        keyboard_irq;
  logic [7:0]  keyboard_data;
  logic        game_tick;
  logic        stack_overflow;
  logic        int_en;
  logic [15:0] PC_curr;
  logic        reti;
  logic        keyboard_hazard, game_tick_hazard, stack_overflow_hazard;
  logic        branch_to_keyboard_ISR, branch_to_gametick_ISR, branch_to_stackoverflow_ISR;
  logic        ld_epc, ld_idr;
  logic [15:0] EPC;
  logic [7:0]  idr_data;
  logic        in_isr;

  int errors = 0;
  int checks = 0;

  interrupt_controller #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .keyboard_irq                (keyboard_irq),
    .keyboard_data               (keyboard_data),
    .game_tick                   (game_tick),
    .stack_overflow              (stack_overflow),
    .int_en                      (int_en),
    .PC_curr                     (PC_curr),
    .reti                        (reti),
    .keyboard_hazard             (keyboard_hazard),
    .game_tick_hazard            (game_tick_hazard),
    .stack_overflow_hazard       (stack_overflow_hazard),
    .branch_to_keyboard_ISR      (branch_to_keyboard_ISR),
    .branch_to_gametick_ISR      (branch_to_gametick_ISR),
    .branch_to_stackoverflow_ISR (branch_to_stackoverflow_ISR),
    .ld_epc                      (ld_epc),
    .ld_idr                      (ld_idr),
    .EPC                         (EPC),
    .idr_data                    (idr_data),
    .in_isr                      (in_isr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: which source is being handled and how many cycles
  // since its service began. A service is DRAIN hazard cycles, one EPC
  // load, an IDR load for the keyboard only, one branch; then the handler.
  int          m_active = -1;
  int          m_phase  = 0;
  logic [2:0]  m_pend   = 3'b000;
  logic [15:0] m_epc    = 16'h0000;
  logic [7:0]  m_idr    = 8'h00;

  function automatic int seq_len(int s);
    return DRAIN + 2 + ((s == KBD) ? 1 : 0);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_outputs();
    logic [2:0] haz, br;
    logic       epc_ld, idr_ld, busy;
    haz = 3'b000; br = 3'b000; epc_ld = 1'b0; idr_ld = 1'b0; busy = 1'b0;
    if (m_active >= 0) begin
      busy = 1'b1;
      if (m_phase < seq_len(m_active) - 1) haz[m_active] = 1'b1;
      if (m_phase == seq_len(m_active) - 1) br[m_active] = 1'b1;
      epc_ld = (m_phase == DRAIN);
      idr_ld = (m_active == KBD) && (m_phase == DRAIN + 1);
    end
    check("in_isr",      16'(in_isr),                      16'(busy));
    check("kbd_hazard",  16'(keyboard_hazard),             16'(haz[KBD]));
    check("tick_hazard", 16'(game_tick_hazard),            16'(haz[TICK]));
    check("ovf_hazard",  16'(stack_overflow_hazard),       16'(haz[OVF]));
    check("kbd_branch",  16'(branch_to_keyboard_ISR),      16'(br[KBD]));
    check("tick_branch", 16'(branch_to_gametick_ISR),      16'(br[TICK]));
    check("ovf_branch",  16'(branch_to_stackoverflow_ISR), 16'(br[OVF]));
    check("ld_epc",      16'(ld_epc),                      16'(epc_ld));
    check("ld_idr",      16'(ld_idr),                      16'(idr_ld));
    check("EPC",         EPC,                              m_epc);
    check("idr_data",    16'(idr_data),                    16'(m_idr));
  endtask

  task automatic model_step();
    logic [2:0] np;
    if (rst) begin
      m_active = -1; m_phase = 0; m_pend = 3'b000; m_epc = 16'h0000; m_idr = 8'h00;
    end else begin
      np = m_pend;
      if (m_active >= 0 && m_phase == seq_len(m_active) - 1) np[m_active] = 1'b0;
      np = np | {stack_overflow, game_tick, keyboard_irq};
      if (keyboard_irq) m_idr = keyboard_data;
      if (m_active < 0) begin
        if (int_en && m_pend != 3'b000) begin
          m_active = m_pend[OVF] ? OVF : (m_pend[TICK] ? TICK : KBD);
          m_phase  = 0;
          m_epc    = PC_curr;
        end
      end else if (m_phase < seq_len(m_active)) begin
        m_phase++;
      end else if (reti) begin
        m_active = -1;
      end
      m_pend = np;
    end
  endtask

  // One clock: check outputs mid-cycle, advance the model, then drop pulses.
  task automatic tick();
    @(negedge clk);
    compare_outputs();
    model_step();
    @(posedge clk);
    #1;
    keyboard_irq = 1'b0; game_tick = 1'b0; stack_overflow = 1'b0;
    reti = 1'b0; rst = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; keyboard_irq = 1'b0; keyboard_data = 8'h00; game_tick = 1'b0;
    stack_overflow = 1'b0; int_en = 1'b0; PC_curr = 16'h0000; reti = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    check("rst_in_isr", 16'(in_isr), 16'd0);
    check("rst_EPC", EPC, 16'h0000);

    // Keyboard path.
    int_en = 1'b1; PC_curr = 16'h0123; keyboard_data = 8'h41; keyboard_irq = 1'b1;
    tick();
    check("kbd_idle_after_pulse", 16'(in_isr), 16'd0);
    tick();
    check("kbd_drain1", 16'(keyboard_hazard), 16'd1);
    check("kbd_epc_capture", EPC, 16'h0123);
    tick();
    check("kbd_drain2", 16'(keyboard_hazard), 16'd1);
    tick();
    check("kbd_ld_epc", 16'(ld_epc), 16'd1);
    tick();
    check("kbd_ld_idr", 16'(ld_idr), 16'd1);
    check("kbd_idr_val", 16'(idr_data), 16'h0041);
    tick();
    check("kbd_branch_now", 16'(branch_to_keyboard_ISR), 16'd1);
    ticks(4);
    check("kbd_in_isr_held", 16'(in_isr), 16'd1);
    reti = 1'b1;
    tick();
    check("kbd_reti_idle", 16'(in_isr), 16'd0);

    // Simultaneous tick + overflow: overflow first, tick right after reti.
    PC_curr = 16'h0200; game_tick = 1'b1; stack_overflow = 1'b1;
    ticks(2);
    check("sim_ovf_first", 16'(stack_overflow_hazard), 16'd1);
    check("sim_tick_waits", 16'(game_tick_hazard), 16'd0);
    ticks(3);
    check("sim_ovf_branch", 16'(branch_to_stackoverflow_ISR), 16'd1);
    ticks(2);
    reti = 1'b1;
    tick();
    tick();
    check("sim_tick_next", 16'(game_tick_hazard), 16'd1);
    ticks(5);
    reti = 1'b1;
    tick();

    // Masking.
    int_en = 1'b0; keyboard_data = 8'h22; keyboard_irq = 1'b1;
    ticks(6);
    check("mask_idle", 16'(in_isr), 16'd0);
    int_en = 1'b1;
    tick();
    check("mask_release", 16'(keyboard_hazard), 16'd1);
    ticks(6);

    // No nesting: tick pulse during ISR waits for reti.
    game_tick = 1'b1;
    ticks(4);
    check("nest_held", 16'(game_tick_hazard), 16'd0);
    reti = 1'b1;
    tick();
    tick();
    check("nest_after_reti", 16'(game_tick_hazard), 16'd1);
    ticks(5);
    reti = 1'b1;
    tick();
    // Stray reti in IDLE.
    reti = 1'b1;
    tick();
    check("stray_reti", 16'(in_isr), 16'd0);

    // Reset in SAVE_EPC.
    PC_curr = 16'h0777; game_tick = 1'b1; keyboard_irq = 1'b1; keyboard_data = 8'h99;
    ticks(4);
    check("pre_rst_ld_epc", 16'(ld_epc), 16'd1);
    rst = 1'b1;
    tick();
    check("rst_mid_in_isr", 16'(in_isr), 16'd0);
    check("rst_mid_idr", 16'(idr_data), 16'h0000);
    ticks(5);
    check("rst_mid_pending_gone", 16'(in_isr), 16'd0);

    // Pulse coinciding with reset is dropped.
    rst = 1'b1; keyboard_irq = 1'b1; keyboard_data = 8'h5A;
    ticks(3);
    check("rst_drops_pulse", 16'(in_isr), 16'd0);

    // Set beats clear in keyboard BRANCH.
    keyboard_data = 8'h30; keyboard_irq = 1'b1;
    ticks(6);
    check("sbc_branch", 16'(branch_to_keyboard_ISR), 16'd1);
    keyboard_data = 8'h55; keyboard_irq = 1'b1;
    ticks(3);
    reti = 1'b1;
    tick();
    tick();
    check("sbc_second_service", 16'(keyboard_hazard), 16'd1);
    ticks(6);
    reti = 1'b1;
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      keyboard_irq   = ($urandom_range(0, 15) == 0);
      keyboard_data  = 8'($urandom);
      game_tick      = ($urandom_range(0, 15) == 0);
      stack_overflow = ($urandom_range(0, 23) == 0);
      int_en         = ($urandom_range(0, 3) != 0);
      PC_curr        = 16'($urandom);
      reti           = ($urandom_range(0, 5) == 0);
      rst            = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
